// File: rtl/wide_add_seq_if.sv
// Requester-side bundle for wide_add_seq: start/done handshake, operands, result.
// Latency: none, wires only.
// Backpressure: start is accepted only while busy is low; requests made during a run are dropped.
interface wide_add_seq_if #(
  parameter int WORDS = 4
);
  localparam int W = 16 * WORDS;

  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] S;
  logic         cout;

  // Requester side: issues operands, observes status and result.
  modport master (
    output start, A, B, cin,
    input  busy, done, S, cout
  );

  // Sequencer side.
  modport slave (
    input  start, A, B, cin,
    output busy, done, S, cout
  );
endinterface

// File: rtl/wide_add_seq.sv
// Sequences one shared 16-bit adder over WORDS words, LSW first, chaining the carry.
// Latency: start accepted at edge k, done high in cycle k+WORDS+1; one add per WORDS+1 cycles.
// Backpressure: start is ignored while busy (RUN); a start in the DONE cycle is taken back-to-back.
module wide_add_seq #(
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  wide_add_seq_if.slave req,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  output logic        add_cin,
  input  logic [15:0] add_s,
  input  logic        add_cout
);

  localparam int W  = 16 * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q,   idx_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  a_q,     a_d;
  logic [W-1:0]  b_q,     b_d;
  logic [W-1:0]  s_q,     s_d;
  logic          cout_q,  cout_d;

  logic          accept;

  // A request is taken in IDLE and also in DONE, so back-to-back adds lose no cycle.
  assign accept = req.start && (state_q != RUN);

  // Next-state and datapath: capture operands on accept, one word per RUN cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    cout_d  = cout_q;

    case (state_q)
      RUN: begin
        s_d[16*idx_q +: 16] = add_s;
        carry_d             = add_cout;
        if (idx_q == LAST_IDX) begin
          // Index returns to 0 so it never exceeds WORDS-1 for non-power-of-two WORDS.
          cout_d  = add_cout;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Accept overrides the IDLE/DONE defaults above; the old result is cleared on entry to RUN.
    if (accept) begin
      a_d     = req.A;
      b_d     = req.B;
      carry_d = req.cin;
      idx_d   = '0;
      s_d     = '0;
      cout_d  = 1'b0;
      state_d = RUN;
    end
  end

  // State and datapath registers; reset aborts any run and discards the partial sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
    end
  end

  // Adder pins come straight from registers (full cycle to settle) and sit at 0 outside RUN.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state_q == RUN) begin
      add_a   = a_q[16*idx_q +: 16];
      add_b   = b_q[16*idx_q +: 16];
      add_cin = carry_q;
    end
  end

  assign req.busy = (state_q == RUN);
  assign req.done = (state_q == DONE);
  assign req.S    = s_q;
  assign req.cout = cout_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// Directed bench for wide_add_seq with WORDS=4 and a behavioural 16-bit adder on the add_* pins.
// Each scenario task drives stimulus and checks against hand-computed sums.
// Inputs change and outputs are sampled on the falling edge.
module tb_wide_add_seq;

  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  logic        clk;
  logic        rst;
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic        add_cin;
  logic [15:0] add_s;
  logic        add_cout;

  int checks;
  int errors;

  wide_add_seq_if #(.WORDS(WORDS)) bus ();

  wide_add_seq #(.WORDS(WORDS)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (bus),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_s    (add_s),
    .add_cout (add_cout)
  );

  // Stand-in for the shared bit_16 ripple adder.
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {16'b0, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands with start high for one edge; returns at the negedge of the first RUN cycle.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    bus.cin   = c;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Called at the negedge of RUN cycle 1; records the cycle done first rises and busy cycles over 12 cycles.
  task automatic observe(output int done_cyc, output int busy_cnt, output int done_cnt);
    done_cyc = 0;
    busy_cnt = 0;
    done_cnt = 0;
    for (int c = 1; c <= 12; c++) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (c < 12) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.S !== '0) begin errors++; $display("FAIL reset_S got=%h exp=0", bus.S); end
    checks++; if (bus.cout !== 1'b0) begin errors++; $display("FAIL reset_cout got=%b exp=0", bus.cout); end
    checks++; if ({add_a, add_b, add_cin} !== 33'd0) begin errors++; $display("FAIL reset_addpins got=%h/%h/%b exp=0", add_a, add_b, add_cin); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_wrap();
    int dc, bc, dn;
    launch({W{1'b1}}, 64'h1, 1'b0);
    checks++; if ({add_a, add_b, add_cin} !== {16'hFFFF, 16'h0001, 1'b0}) begin errors++; $display("FAIL wrap_word0_pins got=%h/%h/%b exp=ffff/0001/0", add_a, add_b, add_cin); end
    @(negedge clk);
    checks++; if ({add_a, add_b, add_cin} !== {16'hFFFF, 16'h0000, 1'b1}) begin errors++; $display("FAIL wrap_word1_pins got=%h/%h/%b exp=ffff/0000/1", add_a, add_b, add_cin); end
    observe(dc, bc, dn);
    // observe started one cycle late here, so done at cycle 5 shows as 4.
    checks++; if (dc !== 4) begin errors++; $display("FAIL wrap_done_cycle got=%0d exp=5", dc + 1); end
    checks++; if (bc !== 3) begin errors++; $display("FAIL wrap_busy_cycles got=%0d exp=4", bc + 1); end
    checks++; if (dn !== 1) begin errors++; $display("FAIL wrap_done_pulses got=%0d exp=1", dn); end
    checks++; if (bus.S !== 64'h0) begin errors++; $display("FAIL wrap_S got=%h exp=0", bus.S); end
    checks++; if (bus.cout !== 1'b1) begin errors++; $display("FAIL wrap_cout got=%b exp=1", bus.cout); end
    checks++; if ({add_a, add_b, add_cin} !== 33'd0) begin errors++; $display("FAIL wrap_idle_pins got=%h/%h/%b exp=0", add_a, add_b, add_cin); end
  endtask

  task automatic test_carry();
    int dc, bc, dn;
    launch(64'h0000_0000_0000_FDE8, 64'h0000_0000_0000_FF3C, 1'b0);
    observe(dc, bc, dn);
    checks++; if (dc !== 5) begin errors++; $display("FAIL carry_done_cycle got=%0d exp=5", dc); end
    checks++; if (bus.S !== 64'h0000_0000_0001_FD24) begin errors++; $display("FAIL carry_S got=%h exp=000000000001fd24", bus.S); end
    checks++; if (bus.cout !== 1'b0) begin errors++; $display("FAIL carry_cout got=%b exp=0", bus.cout); end
  endtask

  task automatic test_cin();
    int dc, bc, dn;
    launch(64'h03E8_0000_0000_03ED, 64'h45, 1'b1);
    observe(dc, bc, dn);
    checks++; if (bus.S !== 64'h03E8_0000_0000_0433) begin errors++; $display("FAIL cin_S got=%h exp=03e8000000000433", bus.S); end
    checks++; if (bus.cout !== 1'b0) begin errors++; $display("FAIL cin_cout got=%b exp=0", bus.cout); end
  endtask

  task automatic test_ignore_busy();
    int dc, bc, dn;
    launch(64'd58135, 64'd3592, 1'b0);
    // Second request lands in RUN cycle 2 and is withdrawn before DONE.
    bus.start = 1'b1;
    bus.A     = {W{1'b1}};
    bus.B     = {W{1'b1}};
    @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL ignore_busy_c2 got=%b exp=1", bus.busy); end
    @(negedge clk);
    bus.start = 1'b0;
    observe(dc, bc, dn);
    // observe started at RUN cycle 3.
    checks++; if (dc !== 3) begin errors++; $display("FAIL ignore_done_cycle got=%0d exp=5", dc + 2); end
    checks++; if (bc !== 2) begin errors++; $display("FAIL ignore_busy_cycles got=%0d exp=4", bc + 2); end
    checks++; if (dn !== 1) begin errors++; $display("FAIL ignore_done_pulses got=%0d exp=1", dn); end
    checks++; if (bus.S !== 64'd61727) begin errors++; $display("FAIL ignore_S got=%0d exp=61727", bus.S); end
    checks++; if (bus.cout !== 1'b0) begin errors++; $display("FAIL ignore_cout got=%b exp=0", bus.cout); end
  endtask

  task automatic test_reset_mid();
    int dc, bc, dn;
    launch(64'h8000_8000_8000_8000, 64'h8000_8000_8000_8000, 1'b0);
    @(negedge clk);
    // Two RUN edges have now written words 0 and 1; assert reset between clock edges.
    rst = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL midrst_done got=%b exp=0", bus.done); end
    checks++; if (bus.S !== 64'h0) begin errors++; $display("FAIL midrst_S got=%h exp=0", bus.S); end
    checks++; if (bus.cout !== 1'b0) begin errors++; $display("FAIL midrst_cout got=%b exp=0", bus.cout); end
    checks++; if ({add_a, add_b, add_cin} !== 33'd0) begin errors++; $display("FAIL midrst_addpins got=%h/%h/%b exp=0", add_a, add_b, add_cin); end
    @(negedge clk);
    rst = 1'b0;
    launch(64'h8000_8000_8000_8000, 64'h8000_8000_8000_8000, 1'b0);
    observe(dc, bc, dn);
    checks++; if (dc !== 5) begin errors++; $display("FAIL midrst_fresh_done got=%0d exp=5", dc); end
    checks++; if (bus.S !== 64'h0001_0001_0001_0000) begin errors++; $display("FAIL midrst_fresh_S got=%h exp=0001000100010000", bus.S); end
    checks++; if (bus.cout !== 1'b1) begin errors++; $display("FAIL midrst_fresh_cout got=%b exp=1", bus.cout); end
  endtask

  task automatic test_back_to_back();
    int dc, bc, dn;
    bit seen;
    launch(64'd1, 64'd2, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (bus.done) seen = 1'b1;
      else @(negedge clk);
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL b2b_first_done got=timeout exp=done"); end
    checks++; if (bus.S !== 64'd3) begin errors++; $display("FAIL b2b_first_S got=%0d exp=3", bus.S); end
    // Request in the DONE cycle.
    bus.start = 1'b1;
    bus.A     = 64'd15124;
    bus.B     = 64'd5383;
    bus.cin   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept_busy got=%b exp=1", bus.busy); end
    observe(dc, bc, dn);
    checks++; if (dc !== 5) begin errors++; $display("FAIL b2b_done_cycle got=%0d exp=5", dc); end
    checks++; if (bus.S !== 64'd20508) begin errors++; $display("FAIL b2b_S got=%0d exp=20508", bus.S); end
    checks++; if (bus.cout !== 1'b0) begin errors++; $display("FAIL b2b_cout got=%b exp=0", bus.cout); end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.cin   = 1'b0;

    test_reset();
    test_wrap();
    test_carry();
    test_cin();
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wide_add_seq.md
Name: wide_add_seq

Overview:
- Multi-cycle controller that sequences one external 16-bit ripple adder (bit_16) to add two WORDS×16-bit operands, least-significant word first.
- Chains the carry between words through an internal carry register.
- Sits between a requester using a start/done handshake and the shared bit_16 instance, whose A/B/cin/S/cout pins it drives and samples.

Parameters:
- WORDS, 4, number of 16-bit words per operand; total operand width W = 16*WORDS; legal range 2..16.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request pulse; sampled only when not busy.
- A  in  W  operand A; sampled at the accepted start edge only.
- B  in  W  operand B; sampled at the accepted start edge only.
- cin  in  1  carry-in to word 0; sampled with A and B.
- busy  out  1  high while an addition is in progress.
- done  out  1  one-cycle pulse when S and cout become valid.
- S  out  W  registered sum; holds its value until the next accepted start.
- cout  out  1  registered final carry-out.
- add_a  out  16  to bit_16 A.
- add_b  out  16  to bit_16 B.
- add_cin  out  1  to bit_16 cin.
- add_s  in  16  from bit_16 S.
- add_cout  in  1  from bit_16 cout.

Behaviour:
- Reset:
  - State = IDLE.
  - busy=0, done=0, S=0, cout=0.
  - Word index and carry register = 0.
  - Operand registers = 0.
  - add_a=0, add_b=0, add_cin=0.
  - Reset asserted mid-operation aborts immediately; the partial sum is discarded and S reads 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0.
  - start=1 at a clock edge latches A, B and cin into operand and carry registers, sets idx=0, moves to RUN.
  - The transition into RUN clears S and cout to 0.
- RUN:
  - busy=1.
  - add_a = A_reg[16*idx +: 16], add_b = B_reg[16*idx +: 16], add_cin = carry_reg. These are combinational from registers, so the adder has one full cycle to settle.
  - Each edge: S[16*idx +: 16] <= add_s, carry_reg <= add_cout, idx <= idx+1.
  - On the edge where idx == WORDS-1: cout <= add_cout and the state moves to DONE.
- DONE:
  - busy=0, done=1 for exactly one cycle.
  - Next edge returns to IDLE, or goes straight to RUN if start=1 (back-to-back accepted).
- Latency: start accepted at edge k; RUN occupies cycles k+1..k+WORDS; done=1 in cycle k+WORDS+1. Throughput is one addition per WORDS+1 cycles.
- start while in RUN is ignored; no queuing, no error flag.
- Adder pins in IDLE/DONE are driven to 0, so the shared adder sees no spurious toggling.
- Arithmetic: {cout,S} = A + B + cin, modulo 2^(W+1), unsigned. Full wrap-around (all-ones + 1) yields S=0, cout=1.
- Operand changes on A/B/cin after acceptance have no effect on the result.
- idx width = clog2(WORDS); it never exceeds WORDS-1.

Test Plan (WORDS=4, bench instantiates bit_16 wired to add_* ports):
- A=64'hFFFF_FFFF_FFFF_FFFF, B=64'h1, cin=0, start pulse → done exactly 5 cycles after start edge, S=0, cout=1; busy high for 4 cycles.
- A=64'h0000_0000_0000_FDE8 (65000), B=64'h0000_0000_0000_FF3C (65340), cin=0 → S=64'h0000_0000_0001_FD24, cout=0 (word-0 carry propagates into word 1).
- A=64'h3E8_0000_0000_03ED, B=64'h45, cin=1 → S=64'h03E8_0000_0000_0433 (1005+69+1=1075 in word 0), cout=0.
- During RUN of A=64'd58135, B=64'd3592, assert start with A=B=all-ones → second request ignored; S=64'd61727, cout=0; busy never drops early.
- Start A=B=64'h8000_8000_8000_8000, assert rst after 2 RUN cycles → busy, done, S, cout and add_* all 0 asynchronously, without waiting for a clock edge. A fresh start after deassert gives S=64'h0001_0001_0001_0000, cout=1.
- Start asserted in the DONE cycle with A=64'd15124, B=64'd5383, cin=1 → accepted back-to-back; done 5 cycles later, S=64'd20508, cout=0.
